// File: rtl/dm_pkg.sv
// Shared definitions for the MEM-stage data memory: access size codes, controller
// state encoding and the byte-enable helper.
package dm_pkg;

    typedef enum logic [1:0] {
        DM_SZ_BYTE = 2'b00,
        DM_SZ_HALF = 2'b01,
        DM_SZ_WORD = 2'b10,
        DM_SZ_RSVD = 2'b11
    } dm_size_e;

    typedef enum logic {
        DM_ST_CLEAR = 1'b0,
        DM_ST_READY = 1'b1
    } dm_state_e;

    function automatic logic [3:0] dm_byte_en(input logic [1:0] size, input logic [1:0] lane);
        logic [3:0] be;
        case (size)
            DM_SZ_BYTE: be = 4'b0001 << lane;
            DM_SZ_HALF: be = 4'b0011 << lane;
            DM_SZ_WORD: be = 4'b1111;
            default:    be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/dm_bank_ctrl_if.sv
// Request/response bundle between the MEM stage (master) and the data memory (slave).
interface dm_bank_ctrl_if;

    logic        soft_clear;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] A;
    logic [31:0] D_write;
    logic [31:0] PC;
    logic        req_ready;
    logic        rd_valid;
    logic [31:0] D_read;
    logic        err_align;
    logic        err_range;
    logic        busy;

    modport master (
        output soft_clear, req_valid, req_we, req_size, req_unsigned, A, D_write, PC,
        input  req_ready, rd_valid, D_read, err_align, err_range, busy
    );

    modport slave (
        input  soft_clear, req_valid, req_we, req_size, req_unsigned, A, D_write, PC,
        output req_ready, rd_valid, D_read, err_align, err_range, busy
    );

endinterface

// File: rtl/dm_lane_align.sv
// Combinational lane logic: store data steering with byte enables, and load lane
// extraction with sign/zero extension.
module dm_lane_align
    import dm_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_lane,
    input  logic [31:0] st_data,
    output logic [3:0]  st_be,
    output logic [31:0] st_word,
    input  logic [1:0]  ld_size,
    input  logic [1:0]  ld_lane,
    input  logic        ld_unsigned,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    function automatic logic [31:0] ext8(input logic [7:0] b, input logic uns);
        return uns ? {24'h0, b} : {{24{b[7]}}, b};
    endfunction

    function automatic logic [31:0] ext16(input logic [15:0] h, input logic uns);
        return uns ? {16'h0, h} : {{16{h[15]}}, h};
    endfunction

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Stores replicate the right-justified data onto every lane; the enables pick one.
    always_comb begin
        st_be = dm_byte_en(st_size, st_lane);
        case (st_size)
            DM_SZ_BYTE: st_word = {4{st_data[7:0]}};
            DM_SZ_HALF: st_word = {2{st_data[15:0]}};
            default:    st_word = st_data;
        endcase
    end

    always_comb begin
        byte_sel = 8'(ld_word >> {ld_lane, 3'b000});
        half_sel = 16'(ld_word >> {ld_lane[1], 4'b0000});
        case (ld_size)
            DM_SZ_BYTE: ld_data = ext8(byte_sel, ld_unsigned);
            DM_SZ_HALF: ld_data = ext16(half_sel, ld_unsigned);
            default:    ld_data = ld_word;
        endcase
    end

endmodule

// File: rtl/dm_bank_ctrl.sv
// MEM-stage data memory: byte/half/word access, alignment and range faults, one-cycle
// registered read, zeroing sweep after reset. Define DM_TRACE_EN to print committed stores.
module dm_bank_ctrl
    import dm_pkg::*;
#(
    parameter int          DEPTH_WORDS = 3072,
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         RESET_N,
    dm_bank_ctrl_if.slave bus
);

    localparam int          AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] SPAN     = 32'(4 * DEPTH_WORDS);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH_WORDS - 1);

    logic [31:0] mem [DEPTH_WORDS];

    dm_state_e   state;
    logic [AW-1:0] clr_idx;

    logic [31:0] offset_p0;
    logic [AW-1:0] idx_p0;
    logic [1:0]  lane_p0;
    logic        mis_p0, oor_p0, fault_p0, accept_p0, st_p0, ld_p0;
    logic [3:0]  be_p0;
    logic [31:0] st_word_p0;

    logic        vld_p1, fault_p1, err_align_p1, err_range_p1;
    logic [31:0] rdata_p1;
    logic [1:0]  size_p1, lane_p1;
    logic        uns_p1;
    logic [31:0] ld_data_p1;
    logic [31:0] dread_q;

    // ---- p0: request decode and fault classification
    assign offset_p0 = bus.A - ADDR_BASE;
    assign idx_p0    = offset_p0[AW+1:2];
    assign lane_p0   = bus.A[1:0];
    assign oor_p0    = (offset_p0 >= SPAN);

    always_comb begin
        case (bus.req_size)
            DM_SZ_BYTE: mis_p0 = 1'b0;
            DM_SZ_HALF: mis_p0 = bus.A[0];
            DM_SZ_WORD: mis_p0 = |bus.A[1:0];
            default:    mis_p0 = 1'b1;
        endcase
    end

    assign accept_p0 = (state == DM_ST_READY) && bus.req_valid && !bus.soft_clear;
    assign fault_p0  = mis_p0 || oor_p0;
    assign st_p0     = accept_p0 && bus.req_we && !fault_p0;
    assign ld_p0     = accept_p0 && !bus.req_we && !fault_p0;

    dm_lane_align u_lane (
        .st_size     (bus.req_size),
        .st_lane     (lane_p0),
        .st_data     (bus.D_write),
        .st_be       (be_p0),
        .st_word     (st_word_p0),
        .ld_size     (size_p1),
        .ld_lane     (lane_p1),
        .ld_unsigned (uns_p1),
        .ld_word     (rdata_p1),
        .ld_data     (ld_data_p1)
    );

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            state   <= DM_ST_CLEAR;
            clr_idx <= '0;
        end else if (bus.soft_clear) begin
            state   <= DM_ST_CLEAR;
            clr_idx <= '0;
        end else if (state == DM_ST_CLEAR) begin
            if (clr_idx == LAST_IDX) begin
                state   <= DM_ST_READY;
                clr_idx <= '0;
            end else begin
                clr_idx <= clr_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == DM_ST_CLEAR) begin
            mem[clr_idx] <= '0;
        end else if (st_p0) begin
            for (int b = 0; b < 4; b++) begin
                if (be_p0[b]) mem[idx_p0][8*b +: 8] <= st_word_p0[8*b +: 8];
            end
        end
    end

    // ---- p1: registered array read and response flags
    always_ff @(posedge clk) begin
        if (ld_p0) begin
            rdata_p1 <= mem[idx_p0];
            size_p1  <= bus.req_size;
            lane_p1  <= lane_p0;
            uns_p1   <= bus.req_unsigned;
        end
    end

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            vld_p1       <= 1'b0;
            fault_p1     <= 1'b0;
            err_align_p1 <= 1'b0;
            err_range_p1 <= 1'b0;
            dread_q      <= '0;
        end else begin
            vld_p1       <= ld_p0;
            fault_p1     <= accept_p0 && fault_p0;
            err_align_p1 <= accept_p0 && mis_p0;
            err_range_p1 <= accept_p0 && !mis_p0 && oor_p0;
            if (vld_p1)        dread_q <= ld_data_p1;
            else if (fault_p1) dread_q <= '0;
        end
    end

    assign bus.req_ready = (state == DM_ST_READY);
    assign bus.busy      = (state == DM_ST_CLEAR);
    assign bus.rd_valid  = vld_p1;
    assign bus.err_align = err_align_p1;
    assign bus.err_range = err_range_p1;
    assign bus.D_read    = vld_p1 ? ld_data_p1 : (fault_p1 ? 32'h0 : dread_q);

`ifdef DM_TRACE_EN
    logic [31:0] merged_p0;

    always_comb begin
        merged_p0 = mem[idx_p0];
        for (int b = 0; b < 4; b++) begin
            if (be_p0[b]) merged_p0[8*b +: 8] = st_word_p0[8*b +: 8];
        end
    end

    always @(posedge clk) begin
        if (RESET_N && st_p0)
            $display("@%h: *%h <= %h", bus.PC, {bus.A[31:2], 2'b00}, merged_p0);
    end
`else
    logic unused_pc;
    assign unused_pc = ^bus.PC;
`endif

endmodule

// File: tb/tb_dm_bank_ctrl.sv
// Directed bench for dm_bank_ctrl with a 16-word array.
module tb_dm_bank_ctrl;
    import dm_pkg::*;

    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic RESET_N;
    int   checks = 0;
    int   errors = 0;
    int   n;

    dm_bank_ctrl_if bus ();

    dm_bank_ctrl #(.DEPTH_WORDS(DEPTH), .ADDR_BASE(32'h0000_0000)) dut (
        .clk     (clk),
        .RESET_N (RESET_N),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.A            = a;
        bus.D_write      = d;
        bus.PC           = bus.PC + 32'd4;
    endtask

    task automatic idle();
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic load(input string tag, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] exp);
        req(1'b0, sz, uns, a, 32'h0);
        idle();
        chk({tag, "_rdv"}, 32'(bus.rd_valid), 32'd1);
        chk(tag, bus.D_read, exp);
    endtask

    task automatic store(input string tag, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] d);
        req(1'b1, sz, 1'b0, a, d);
        idle();
        chk({tag, "_rdv"}, 32'(bus.rd_valid), 32'd0);
    endtask

    task automatic fault(input string tag, input logic we, input logic [1:0] sz,
                         input logic [31:0] a, input logic exp_al, input logic exp_rg);
        req(we, sz, 1'b0, a, 32'hA5A5_A5A5);
        idle();
        chk({tag, "_al"}, 32'(bus.err_align), 32'(exp_al));
        chk({tag, "_rg"}, 32'(bus.err_range), 32'(exp_rg));
        chk({tag, "_rdv"}, 32'(bus.rd_valid), 32'd0);
        chk({tag, "_dr"}, bus.D_read, 32'h0);
        idle();
        chk({tag, "_end"}, 32'({bus.err_align, bus.err_range}), 32'd0);
    endtask

    task automatic wait_ready(output int cnt);
        cnt = 0;
        do begin
            @(posedge clk);
            #1;
            cnt++;
        end while (!bus.req_ready && cnt < 200);
    endtask

    initial begin
        bus.soft_clear   = 1'b0;
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = DM_SZ_WORD;
        bus.req_unsigned = 1'b0;
        bus.A            = 32'h0;
        bus.D_write      = 32'h0;
        bus.PC           = 32'h0040_0000;
        RESET_N          = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_busy",  32'(bus.busy), 32'd1);
        chk("rst_rdv",   32'(bus.rd_valid), 32'd0);
        chk("rst_dread", bus.D_read, 32'h0);
        chk("rst_errs",  32'({bus.err_align, bus.err_range}), 32'd0);

        RESET_N = 1'b1;
        wait_ready(n);
        chk("sweep_cycles", 32'(n), 32'(DEPTH));
        chk("ready_busy", 32'(bus.busy), 32'd0);

        load("lw_init",  DM_SZ_WORD, 1'b0, 32'h08, 32'h0);
        load("lw_lastw", DM_SZ_WORD, 1'b0, 32'h3C, 32'h0);

        store("sw_10", DM_SZ_WORD, 32'h10, 32'h8899_AABB);
        load("lb_13",  DM_SZ_BYTE, 1'b0, 32'h13, 32'hFFFF_FF88);
        load("lbu_13", DM_SZ_BYTE, 1'b1, 32'h13, 32'h0000_0088);
        load("lb_10",  DM_SZ_BYTE, 1'b0, 32'h10, 32'hFFFF_FFBB);
        load("lh_10",  DM_SZ_HALF, 1'b0, 32'h10, 32'hFFFF_AABB);
        load("lhu_12", DM_SZ_HALF, 1'b1, 32'h12, 32'h0000_8899);
        idle();
        chk("hold_rdv", 32'(bus.rd_valid), 32'd0);
        chk("hold_dr",  bus.D_read, 32'h0000_8899);

        store("sw_20", DM_SZ_WORD, 32'h20, 32'h1122_3344);
        store("sb_21", DM_SZ_BYTE, 32'h21, 32'hFFFF_FF5A);
        load("lw_20a", DM_SZ_WORD, 1'b0, 32'h20, 32'h1122_5A44);
        store("sh_22", DM_SZ_HALF, 32'h22, 32'h1234_BEEF);
        load("lw_20b", DM_SZ_WORD, 1'b0, 32'h20, 32'hBEEF_5A44);

        fault("lw_mis",  1'b0, DM_SZ_WORD, 32'h22, 1'b1, 1'b0);
        fault("sh_mis",  1'b1, DM_SZ_HALF, 32'h13, 1'b1, 1'b0);
        fault("rsvd",    1'b1, DM_SZ_RSVD, 32'h20, 1'b1, 1'b0);
        load("lw_20c", DM_SZ_WORD, 1'b0, 32'h20, 32'hBEEF_5A44);
        load("lw_10c", DM_SZ_WORD, 1'b0, 32'h10, 32'h8899_AABB);
        fault("lw_oor",  1'b0, DM_SZ_WORD, 32'(4 * DEPTH), 1'b0, 1'b1);
        fault("sb_oor",  1'b1, DM_SZ_BYTE, 32'h8000_0001, 1'b0, 1'b1);
        fault("mis_oor", 1'b0, DM_SZ_WORD, 32'h42, 1'b1, 1'b0);

        req(1'b1, DM_SZ_WORD, 1'b0, 32'h30, 32'hCAFE_F00D);
        req(1'b0, DM_SZ_WORD, 1'b0, 32'h30, 32'h0);
        idle();
        chk("b2b_rdv", 32'(bus.rd_valid), 32'd1);
        chk("b2b_dr",  bus.D_read, 32'hCAFE_F00D);

        // soft_clear from READY drops the same-cycle store and reruns the sweep
        @(negedge clk);
        bus.soft_clear = 1'b1;
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_size   = DM_SZ_WORD;
        bus.A          = 32'h10;
        bus.D_write    = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.soft_clear = 1'b0;
        bus.req_valid  = 1'b0;
        chk("sc_busy",  32'(bus.busy), 32'd1);
        chk("sc_ready", 32'(bus.req_ready), 32'd0);
        wait_ready(n);
        chk("sc_cycles", 32'(n), 32'(DEPTH));
        load("sc_lw10", DM_SZ_WORD, 1'b0, 32'h10, 32'h0);
        load("sc_lw20", DM_SZ_WORD, 1'b0, 32'h20, 32'h0);
        load("sc_lw30", DM_SZ_WORD, 1'b0, 32'h30, 32'h0);

        store("sw_30b", DM_SZ_WORD, 32'h30, 32'h1234_5678);
        load("lw_30b", DM_SZ_WORD, 1'b0, 32'h30, 32'h1234_5678);

        // async reset in the middle of a sweep
        @(negedge clk);
        bus.soft_clear = 1'b1;
        @(negedge clk);
        bus.soft_clear = 1'b0;
        repeat (5) @(negedge clk);
        RESET_N = 1'b0;
        #1;
        chk("mrst_busy",  32'(bus.busy), 32'd1);
        chk("mrst_ready", 32'(bus.req_ready), 32'd0);
        chk("mrst_dr",    bus.D_read, 32'h0);
        @(negedge clk);
        RESET_N = 1'b1;
        wait_ready(n);
        chk("mrst_cycles", 32'(n), 32'(DEPTH));
        load("mrst_lw30", DM_SZ_WORD, 1'b0, 32'h30, 32'h0);

        // soft_clear during a sweep restarts it from word 0
        store("sw_3c", DM_SZ_WORD, 32'h3C, 32'h0BAD_F00D);
        @(negedge clk);
        bus.soft_clear = 1'b1;
        @(negedge clk);
        bus.soft_clear = 1'b0;
        repeat (6) @(negedge clk);
        bus.soft_clear = 1'b1;
        @(negedge clk);
        bus.soft_clear = 1'b0;
        wait_ready(n);
        chk("restart_cycles", 32'(n), 32'(DEPTH));
        load("restart_lw3c", DM_SZ_WORD, 1'b0, 32'h3C, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
